record_serializer: RTL
======================

RECORD_SERIALIZER -- requirements
Module: record_serializer

Interface
REQ-001 SHALL have parameter DW, default 48: record width in bits; a multiple of 8, range 8..128.
REQ-002 SHALL have parameter HEX_MODE, default 0: 0 = raw binary bytes; 1 = uppercase ASCII hex followed by CR LF.
REQ-003 SHALL have parameter HEADER_EN, default 1: 1 = prefix every frame with the SYNC byte.
REQ-004 SHALL have parameter SYNC, default 8'hA5: the frame header byte.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port read_empty, input, 1 bit: ring buffer holds no record.
REQ-009 SHALL have port read_clock_enable, output, 1 bit: one-cycle pop strobe to the ring buffer.
REQ-010 SHALL have port read_data, input, DW bits: record; valid in the cycle after a pop strobe.
REQ-011 SHALL have port uart_ready, input, 1 bit: transmitter can accept a byte.
REQ-012 SHALL have port uart_clock_enable, output, 1 bit: one-cycle byte strobe to the transmitter.
REQ-013 SHALL have port uart_data, output, 8 bits: byte presented with uart_clock_enable.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port frame_count, output, 16 bits: number of completed frames; wraps from 16'hFFFF to 0.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, LATCH, SEND and GAP.
REQ-017 IDLE with read_empty=0 SHALL assert read_clock_enable for exactly one cycle and go to FETCH; IDLE with read_empty=1 SHALL stay in IDLE with no strobe.
REQ-018 FETCH SHALL go to LATCH after one cycle; LATCH SHALL capture read_data into the shift register, clear the byte index and go to SEND.
REQ-019 The frame SHALL be: SYNC (if HEADER_EN=1), then the payload, then 8'h0D 8'h0A (only if HEX_MODE=1).
REQ-020 With HEX_MODE=0 the payload SHALL be DW/8 bytes, most significant byte first.
REQ-021 With HEX_MODE=1 the payload SHALL be DW/4 characters, most significant nibble first; nibble 0-9 maps to 8'h30+n and nibble A-F maps to 8'h41+(n-10).
REQ-022 SEND with uart_ready=1 SHALL pulse uart_clock_enable for one cycle with uart_data valid in that same cycle, then go to GAP.
REQ-023 SEND with uart_ready=0 SHALL hold the state and the byte index with no strobe, for an unbounded time.
REQ-024 GAP SHALL last exactly one cycle with uart_ready ignored; it then goes to SEND if bytes remain, else to IDLE with frame_count incremented.
REQ-025 The byte index width SHALL be clog2 of the maximum frame length; total frame length = HEADER_EN + DW/8*(2^HEX_MODE) + 2*HEX_MODE.
REQ-026 SHALL issue at most one pop per frame; no pop while busy=1, even if read_empty=0.
REQ-027 Back-to-back records: IDLE SHALL be entered for one cycle between frames, and the next pop issues in that cycle.
REQ-028 uart_clock_enable and read_clock_enable SHALL never be high in the same cycle.

Reset
REQ-029 While reset=1, all outputs SHALL be 0: read_clock_enable, uart_clock_enable, uart_data=8'h00, busy, frame_count.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; after release, no remaining bytes are sent and the next frame starts from its header.
REQ-031 The FSM SHALL leave IDLE no earlier than the first clock edge after reset deasserts.

Verification
REQ-032 DW=48, HEX_MODE=0, HEADER_EN=1, record 48'h000000803402, uart_ready=1 -> bytes A5 00 00 00 80 34 02, one byte every 2 cycles; frame_count=1.
REQ-033 Same record with HEX_MODE=1 -> bytes A5, then "000000803402" as 30 30 30 30 30 30 38 30 33 34 30 32, then 0D 0A; total 15 bytes.
REQ-034 read_empty=1 held for 100 cycles -> no read_clock_enable pulse; busy=0 throughout.
REQ-035 uart_ready=0 held for 50 cycles after the header is sent -> no strobe during the stall; the remaining bytes follow in order once uart_ready=1; no byte is duplicated or dropped.
REQ-036 Two records queued -> exactly two pops, 2 complete frames, one IDLE cycle between them; frame_count=2.
REQ-037 Reset pulsed after the third byte of a frame -> all outputs 0 during reset; the next frame transmitted is complete and starts with A5.

Source files
------------

// File: rtl/record_serializer.sv
// rtl/record_serializer.sv - pops records from a ring buffer and streams them as framed bytes to a UART
module record_serializer #(
  parameter int         DW        = 48,
  parameter int         HEX_MODE  = 0,
  parameter int         HEADER_EN = 1,
  parameter logic [7:0] SYNC      = 8'hA5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          read_empty,
  output logic          read_clock_enable,
  input  logic [DW-1:0] read_data,
  input  logic          uart_ready,
  output logic          uart_clock_enable,
  output logic [7:0]    uart_data,
  output logic          busy,
  output logic [15:0]   frame_count
);

  // Frame layout: optional SYNC, payload (bytes or hex characters), optional CR LF.
  localparam int PAYLOAD_LEN = (HEX_MODE != 0) ? DW / 4 : DW / 8;
  localparam int FRAME_LEN   = ((HEADER_EN != 0) ? 1 : 0) + PAYLOAD_LEN + ((HEX_MODE != 0) ? 2 : 0);
  localparam int IW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CR_POS      = (FRAME_LEN >= 2) ? FRAME_LEN - 2 : 0;
  localparam int SHIFT       = (HEX_MODE != 0) ? 4 : 8;

  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] CR_IDX   = IW'(CR_POS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [DW-1:0] shreg;
  logic [3:0]    nibble;
  logic [7:0]    hex_char;
  logic [7:0]    cur_byte;
  logic          is_payload;

  assign busy = (state != IDLE);

  // State register; reset drops any frame in progress back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the pop / byte strobes; strobes are forced low while reset is held.
  always_comb begin
    state_nxt         = state;
    read_clock_enable = 1'b0;
    uart_clock_enable = 1'b0;
    uart_data         = 8'h00;
    case (state)
      IDLE: begin
        if (!read_empty) begin
          read_clock_enable = 1'b1;
          state_nxt         = FETCH;
        end
      end
      FETCH: begin
        state_nxt = LATCH;
      end
      LATCH: begin
        state_nxt = SEND;
      end
      SEND: begin
        if (uart_ready) begin
          uart_clock_enable = 1'b1;
          uart_data         = cur_byte;
          state_nxt         = GAP;
        end
      end
      GAP: begin
        state_nxt = (idx == LAST_IDX) ? IDLE : SEND;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (reset) begin
      read_clock_enable = 1'b0;
      uart_clock_enable = 1'b0;
      uart_data         = 8'h00;
    end
  end

  // Select the byte for the current index: header, payload head of the shift register, or trailer.
  always_comb begin
    nibble     = shreg[DW-1 -: 4];
    hex_char   = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    is_payload = 1'b1;
    cur_byte   = (HEX_MODE != 0) ? hex_char : shreg[DW-1 -: 8];
    if ((HEADER_EN != 0) && (idx == '0)) begin
      cur_byte   = SYNC;
      is_payload = 1'b0;
    end else if ((HEX_MODE != 0) && (idx == CR_IDX)) begin
      cur_byte   = 8'h0D;
      is_payload = 1'b0;
    end else if ((HEX_MODE != 0) && (idx == LAST_IDX)) begin
      cur_byte   = 8'h0A;
      is_payload = 1'b0;
    end
  end

  // Record capture, payload shifting after each sent payload item, and byte index advance in GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        LATCH: begin
          shreg <= read_data;
          idx   <= '0;
        end
        SEND: begin
          if (uart_ready && is_payload) begin
            shreg <= shreg << SHIFT;
          end
        end
        GAP: begin
          if (idx != LAST_IDX) begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completed-frame counter, bumped as the last GAP of a frame returns to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if ((state == GAP) && (idx == LAST_IDX)) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule
